// File: rtl/dmem_responder.sv
// dmem_responder: target side of the CPU data-memory port.
// Holds the data RAM and a 32-byte MMIO window containing a cycle counter,
// a console TX FIFO with a valid/ready drain, and a scratch register.
// Optional build macro: DMEM_RESP_ERR_EN adds a sticky dmem_err output that
// flags unmapped or misaligned accesses and is mirrored in TX_STATUS[3].
module dmem_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] DMEM_address,
  input  logic [63:0] DMEM_WriteData,
  input  logic        DMEM_MemWrite,
  input  logic        DMEM_MemRead,
  output logic [63:0] DMEM_ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef DMEM_RESP_ERR_EN
  ,
  output logic        dmem_err
`endif
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // MMIO register word offsets (address bits [4:3])
  localparam logic [1:0] R_CYCLE = 2'd0, R_TXDATA = 2'd1, R_STATUS = 2'd2, R_SCRATCH = 2'd3;

  logic [63:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [63:0]   cycle_q, cycle_d;
  logic [63:0]   scratch_q, scratch_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tx_valid_q, tx_valid_d;
  logic          err_q, err_d;

  logic          ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          full, empty, push, pop, push_ok, status_wr;
  logic [63:0]   status_word;

  // Address decode and FIFO handshake terms
  always_comb begin
    ram_hit   = (DMEM_address[63:AW+3] == '0);
    mmio_hit  = (DMEM_address[63:5] == MMIO_BASE[63:5]);
    ram_idx   = DMEM_address[AW+2:3];
    reg_sel   = DMEM_address[4:3];
    full      = (count_q == CW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    pop       = tx_valid_q & tx_ready;
    push      = rst & DMEM_MemWrite & mmio_hit & (reg_sel == R_TXDATA);
    // A push into a full FIFO still lands if the head leaves on the same edge
    push_ok   = push & (~full | pop);
    status_wr = DMEM_MemWrite & mmio_hit & (reg_sel == R_STATUS);
    status_word = {48'h0, 8'(count_q), 4'h0, err_q, ovf_q, empty, full};
  end

  // Zero-latency read mux; write-only and unmapped locations read as zero
  always_comb begin
    DMEM_ReadData = 64'h0;
    if (DMEM_MemRead) begin
      if (ram_hit) DMEM_ReadData = ram[ram_idx];
      else if (mmio_hit) begin
        case (reg_sel)
          R_CYCLE:   DMEM_ReadData = cycle_q;
          R_STATUS:  DMEM_ReadData = status_word;
          R_SCRATCH: DMEM_ReadData = scratch_q;
          default:   DMEM_ReadData = 64'h0;
        endcase
      end
    end
  end

  // Next-state for counter, scratch, FIFO bookkeeping and sticky flags
  always_comb begin
    cycle_d   = cycle_q + 64'd1;
    scratch_d = scratch_q;
    if (DMEM_MemWrite && mmio_hit && reg_sel == R_SCRATCH) scratch_d = DMEM_WriteData;
    wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push_ok) - CW'(pop);
    tx_valid_d = (count_d != '0);
    ovf_d     = ovf_q;
    if (status_wr) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
`ifdef DMEM_RESP_ERR_EN
    err_d = err_q;
    if (status_wr) err_d = 1'b0;
    if ((DMEM_MemRead || DMEM_MemWrite) &&
        ((!ram_hit && !mmio_hit) || (DMEM_address[2:0] != 3'b000))) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  // Control state; async reset also discards any queued TX bytes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q    <= '0;
      scratch_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // RAM and FIFO storage are not reset; RAM writes are held off during reset
  always_ff @(posedge clk) begin
    if (rst && DMEM_MemWrite && ram_hit) ram[ram_idx] <= DMEM_WriteData;
    if (push_ok) fifo_mem[wr_ptr_q] <= DMEM_WriteData[7:0];
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_valid_q ? fifo_mem[rd_ptr_q] : 8'h00;

`ifdef DMEM_RESP_ERR_EN
  assign dmem_err = err_q;
`else
  // Byte-offset bits have no meaning without the error flag
  logic unused_addr_lo;
  assign unused_addr_lo = ^DMEM_address[2:0];
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, CYCLE, SCRATCH, TX FIFO, reset.
module tb_dmem_responder;
  localparam logic [63:0] CYC = 64'h1000_0000;
  localparam logic [63:0] TXD = 64'h1000_0008;
  localparam logic [63:0] STS = 64'h1000_0010;
  localparam logic [63:0] SCR = 64'h1000_0018;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic        we = 1'b0, re = 1'b0, tx_ready = 1'b0;
  logic [63:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
`ifdef DMEM_RESP_ERR_EN
  logic        dmem_err;
`endif
  int n_cmp = 0, n_err = 0;
  logic [63:0] c1;

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .DMEM_address(addr), .DMEM_WriteData(wdata),
    .DMEM_MemWrite(we), .DMEM_MemRead(re), .DMEM_ReadData(rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef DMEM_RESP_ERR_EN
    , .dmem_err(dmem_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access at the current negedge and let comb settle
  task automatic acc(input logic [63:0] a, input logic [63:0] d, input logic w, input logic r);
    addr = a; wdata = d; we = w; re = r;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // reset state, including MMIO reads while reset is held
    step(); step();
    acc(CYC, 0, 0, 1); check("rst_cycle", rdata, 64'h0);
    acc(SCR, 0, 0, 1); check("rst_scratch", rdata, 64'h0);
    acc(STS, 0, 0, 1); check("rst_status", rdata, 64'h2);
    check("rst_txvalid", {63'h0, tx_valid}, 64'h0);
    check("rst_txdata", {56'h0, tx_data}, 64'h0);
    rst = 1'b1;
    step();

    // RAM write then read, byte offset ignored
    acc(64'h40, 64'hDEAD_BEEF_0123_4567, 1, 0); step();
    acc(64'h40, 0, 0, 1); check("ram_rd40", rdata, 64'hDEAD_BEEF_0123_4567);
    acc(64'h40, 0, 0, 0); check("ram_noread", rdata, 64'h0);
    acc(64'h48, 64'h1111, 1, 0); step();
    acc(64'h48, 64'h2222, 1, 1); check("ram_rw_prewrite", rdata, 64'h1111); step();
    acc(64'h48, 0, 0, 1); check("ram_rw_post", rdata, 64'h2222);
    acc(64'h44, 0, 0, 1); check("ram_rd44", rdata, 64'hDEAD_BEEF_0123_4567); step();

    // scratch, write-only and unmapped reads
    acc(SCR, 64'hCAFE_F00D_5555_AAAA, 1, 0); step();
    acc(SCR, 0, 0, 1); check("scratch", rdata, 64'hCAFE_F00D_5555_AAAA);
    acc(TXD, 0, 0, 1); check("txdata_rd0", rdata, 64'h0);
    acc(64'h2000_0000, 0, 0, 1); check("unmapped_rd", rdata, 64'h0); step();
`ifdef DMEM_RESP_ERR_EN
    check("err_set", {63'h0, dmem_err}, 64'h1);
    acc(STS, 0, 0, 1); check("err_status", rdata & 64'h8, 64'h8);
    acc(STS, 0, 1, 0); step();
    check("err_clr", {63'h0, dmem_err}, 64'h0);
`endif

    // CYCLE increments by one per clock and wraps
    acc(CYC, 0, 0, 1); c1 = rdata; step();
    acc(CYC, 0, 0, 1); check("cycle_diff", rdata - c1, 64'h1);
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.cycle_q;
    acc(CYC, 0, 0, 1); check("cycle_max", rdata, 64'hFFFF_FFFF_FFFF_FFFF); step();
    acc(CYC, 0, 0, 1); check("cycle_wrap", rdata, 64'h0);

    // overflow: 9 pushes into depth 8 with sink stalled
    check("fifo_empty_valid", {63'h0, tx_valid}, 64'h0);
    for (int i = 0; i < 9; i++) begin
      acc(TXD, 64'h41 + 64'(i), 1, 0); step();
      if (i == 0) check("push_latency", {63'h0, tx_valid}, 64'h1);
    end
    acc(STS, 0, 0, 1); check("status_ovf_full", rdata, 64'h805);
    acc(0, 0, 0, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_valid", {63'h0, tx_valid}, 64'h1);
      check("drain_data", {56'h0, tx_data}, 64'h41 + 64'(i));
      step();
    end
    acc(STS, 0, 0, 1);
    check("drained_valid", {63'h0, tx_valid}, 64'h0);
    check("status_empty_ovf", rdata, 64'h6);
    tx_ready = 1'b0;
    acc(STS, 0, 1, 0); step();
    acc(STS, 0, 0, 1); check("status_ovf_clr", rdata, 64'h2); step();

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      acc(TXD, 64'h50 + 64'(i), 1, 0); step();
    end
    tx_ready = 1'b1;
    acc(TXD, 64'h5A, 1, 0); check("full_head", {56'h0, tx_data}, 64'h50); step();
    tx_ready = 1'b0;
    acc(STS, 0, 0, 1); check("status_pushpop", rdata, 64'h801);
    check("stall_hold", {56'h0, tx_data}, 64'h51); step();
    acc(0, 0, 0, 0); check("stall_stable", {56'h0, tx_data}, 64'h51);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("pp_data", {56'h0, tx_data}, (i == 7) ? 64'h5A : 64'h51 + 64'(i));
      step();
    end
    #1; check("pp_done_valid", {63'h0, tx_valid}, 64'h0);
    tx_ready = 1'b0;

    // reset mid-drain discards FIFO; RAM survives
    acc(TXD, 64'h61, 1, 0); step();
    acc(TXD, 64'h62, 1, 0); step();
    acc(STS, 0, 0, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", {63'h0, tx_valid}, 64'h0);
    check("rst_mid_status", rdata, 64'h2);
    acc(64'h40, 64'h0BAD, 1, 0); step();
    rst = 1'b1;
    acc(64'h40, 0, 0, 1); check("ram_kept", rdata, 64'hDEAD_BEEF_0123_4567);
    acc(SCR, 0, 0, 1); check("rst_mid_scratch", rdata, 64'h0);
    acc(0, 0, 0, 0); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
